// File: rtl/tree_router_rr.sv
// tree_router_rr: one node of a tree network. Port 0 faces the parent and
// ports 1..NUM_CHILD face the children. Every input has a small FIFO.
// Every output has a round-robin arbiter over the FIFO heads and a single
// register stage. Packets whose destination cannot be reached from this
// node are discarded at the FIFO head, and each discard is counted.
module tree_router_rr #(
    parameter int                    WIDTH_packet = 14,
    parameter int                    WIDTH_addr   = 3,
    parameter int                    NUM_CHILD    = 2,
    parameter int                    DEPTH        = 2,
    parameter logic [WIDTH_addr-1:0] MASK         = 3'b110,
    parameter logic [WIDTH_addr-1:0] ADDR         = 3'b000,
    parameter int                    CSEL_LSB     = 0,
    parameter bit                    IS_ROOT      = 1'b0,
    localparam int                   NP           = NUM_CHILD + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NP*WIDTH_packet-1:0] in_data,
    input  logic [NP-1:0]              in_valid,
    output logic [NP-1:0]              in_ready,
    output logic [NP*WIDTH_packet-1:0] out_data,
    output logic [NP-1:0]              out_valid,
    input  logic [NP-1:0]              out_ready,
    output logic [7:0]                 drop_cnt
);

    // CW: width of the child-select field. PW: width of a port index.
    // AW: width of a FIFO slot index.
    localparam int CW = $clog2(NUM_CHILD);
    localparam int PW = $clog2(NP);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FIFO_FULL_CNT = (AW+1)'(DEPTH);

    // Per-input FIFO storage and bookkeeping
    logic [WIDTH_packet-1:0] fifo_mem [NP][DEPTH];
    logic [AW-1:0]           rd_ptr   [NP];
    logic [AW-1:0]           wr_ptr   [NP];
    logic [AW:0]             fifo_cnt [NP];
    logic [NP-1:0]           fifo_full;
    logic [NP-1:0]           push;
    logic [NP-1:0]           pop;

    // Decoded view of each FIFO head
    logic [NP-1:0]           head_valid;
    logic [NP-1:0]           head_local;
    logic [NP-1:0]           head_illegal;
    logic [NP-1:0]           drop;
    logic [WIDTH_packet-1:0] head_data   [NP];
    logic [WIDTH_addr-1:0]   head_dest   [NP];
    logic [CW-1:0]           head_csel   [NP];
    logic [PW-1:0]           head_target [NP];

    // Arbitration: req[o][p] means that the head of input p wants output o
    logic [NP-1:0]           req [NP];
    logic [NP-1:0]           load_en;
    logic [NP-1:0]           grant_valid;
    logic [PW-1:0]           grant_idx [NP];
    logic [PW-1:0]           rr_ptr    [NP];

    // Output register stage
    logic [NP-1:0]           out_valid_r;
    logic [WIDTH_packet-1:0] out_data_r [NP];

    // Drop counter next value, wide enough to hold every port dropping at once
    logic [9:0]              drop_sum;

    // in_ready depends only on the FIFO fill level. This keeps out_ready off the
    // upstream handshake path. At the root, the parent input accepts
    // everything and stores none of it.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            fifo_full[p] = (fifo_cnt[p] == FIFO_FULL_CNT);
            if (IS_ROOT && p == 0) begin
                in_ready[p] = 1'b1;
                push[p]     = 1'b0;
            end else begin
                in_ready[p] = !fifo_full[p];
                push[p]     = in_valid[p] && !fifo_full[p];
            end
        end
    end

    // Decode the destination of every FIFO head into a target port and a legality flag
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            head_valid[p] = (fifo_cnt[p] != '0);
            head_data[p]  = fifo_mem[p][rd_ptr[p]];
            head_dest[p]  = head_data[p][WIDTH_packet-1 -: WIDTH_addr];
            head_csel[p]  = head_dest[p][CSEL_LSB +: CW];
            head_local[p] = ((head_dest[p] & MASK) == (ADDR & MASK));
            if (head_local[p]) begin
                head_illegal[p] = (int'(head_csel[p]) >= NUM_CHILD);
                head_target[p]  = PW'(head_csel[p]) + PW'(1);
            end else begin
                head_illegal[p] = (p == 0) || IS_ROOT;
                head_target[p]  = '0;
            end
            drop[p] = head_valid[p] && head_illegal[p];
        end
    end

    // Build the request matrix. Dropped heads never request an output.
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            for (int p = 0; p < NP; p++) begin
                req[o][p] = head_valid[p] && !head_illegal[p] &&
                            (head_target[p] == PW'(o));
            end
        end
    end

    // Round-robin grant per output. The search starts one past the last winner.
    // An output grants only when its register can take a new packet.
    always_comb begin : arbitrate
        int idx;
        idx = 0;
        for (int o = 0; o < NP; o++) begin
            load_en[o]     = (IS_ROOT && o == 0) ? 1'b0 : (!out_valid_r[o] || out_ready[o]);
            grant_valid[o] = 1'b0;
            grant_idx[o]   = '0;
            for (int i = 1; i <= NP; i++) begin
                idx = (int'(rr_ptr[o]) + i) % NP;
                if (load_en[o] && !grant_valid[o] && req[o][idx]) begin
                    grant_valid[o] = 1'b1;
                    grant_idx[o]   = PW'(idx);
                end
            end
        end
    end

    // An input pops when its head is dropped or when an output grants it.
    // Each head targets one output only, so an input pops at most once per cycle.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            pop[p] = drop[p];
            for (int o = 0; o < NP; o++) begin
                if (grant_valid[o] && grant_idx[o] == PW'(p)) begin
                    pop[p] = 1'b1;
                end
            end
        end
    end

    // Sum this cycle's drops into the counter, saturating at 255
    always_comb begin
        drop_sum = {2'b00, drop_cnt};
        for (int p = 0; p < NP; p++) begin
            drop_sum = drop_sum + {9'b0, drop[p]};
        end
    end

    // Update the FIFO pointers and fill counts. Reset empties every FIFO at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                rd_ptr[p]   <= '0;
                wr_ptr[p]   <= '0;
                fifo_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (push[p]) begin
                    wr_ptr[p] <= wr_ptr[p] + AW'(1);
                end
                if (pop[p]) begin
                    rd_ptr[p] <= rd_ptr[p] + AW'(1);
                end
                fifo_cnt[p] <= fifo_cnt[p] + {{AW{1'b0}}, push[p]} - {{AW{1'b0}}, pop[p]};
            end
        end
    end

    // Write into FIFO storage. Its contents are don't-care while the fill count is zero.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (push[p]) begin
                fifo_mem[p][wr_ptr[p]] <= in_data[p*WIDTH_packet +: WIDTH_packet];
            end
        end
    end

    // Load the output registers and move the round-robin pointers. Data holds while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int o = 0; o < NP; o++) begin
                out_valid_r[o] <= 1'b0;
                out_data_r[o]  <= '0;
                rr_ptr[o]      <= PW'(NP - 1);
            end
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (grant_valid[o]) begin
                    out_valid_r[o] <= 1'b1;
                    out_data_r[o]  <= head_data[grant_idx[o]];
                    rr_ptr[o]      <= grant_idx[o];
                end else if (out_ready[o]) begin
                    out_valid_r[o] <= 1'b0;
                end
            end
        end
    end

    // Saturating count of discarded packets
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop_sum > 10'd255) begin
            drop_cnt <= 8'hFF;
        end else begin
            drop_cnt <= drop_sum[7:0];
        end
    end

    assign out_valid = out_valid_r;

    for (genvar o = 0; o < NP; o++) begin : g_out
        assign out_data[o*WIDTH_packet +: WIDTH_packet] = out_data_r[o];
    end

endmodule

// File: tb/tb_tree_router_rr.sv
// tb_tree_router_rr: directed bench for tree_router_rr using the default parameters.
// Packets are written into per-port source lists. The driver presents them
// with valid/ready handshakes. Every packet that should reach an output is
// pushed into that output's expected queue. A monitor process pops the queue
// and compares each time an output hands a packet downstream.
module tb_tree_router_rr;

    localparam int W  = 14;
    localparam int NP = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP*W-1:0] in_data;
    logic [NP-1:0]   in_valid;
    logic [NP-1:0]   in_ready;
    logic [NP*W-1:0] out_data;
    logic [NP-1:0]   out_valid;
    logic [NP-1:0]   out_ready;
    logic [7:0]      drop_cnt;

    int n_compared = 0;
    int n_mismatch = 0;

    // Per-port source lists consumed by the driver
    logic [W-1:0] src_mem [NP][512];
    int           src_wr  [NP];
    int           src_rd  [NP];
    int           acc_cnt [NP];

    // Expected packets per output, in the order they must appear
    logic [W-1:0] exp_q0 [$];
    logic [W-1:0] exp_q1 [$];
    logic [W-1:0] exp_q2 [$];

    tree_router_rr dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // One comparison: count it, and report it when it fails
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        n_compared++;
        if (actual !== required) begin
            n_mismatch++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, required);
        end
    endtask

    // Queue a packet on input p. A non-negative exp_port also adds it to that output's expected queue.
    task automatic send(input int p, input logic [2:0] dest, input logic [10:0] payload, input int exp_port);
        logic [W-1:0] pkt;
        pkt = {dest, payload};
        src_mem[p][src_wr[p]] = pkt;
        src_wr[p]++;
        case (exp_port)
            0: exp_q0.push_back(pkt);
            1: exp_q1.push_back(pkt);
            2: exp_q2.push_back(pkt);
            default: ;
        endcase
    endtask

    // Drive each input with the head of its source list, or idle it
    task automatic set_inputs();
        for (int p = 0; p < NP; p++) begin
            if (src_rd[p] < src_wr[p]) begin
                in_valid[p]       = 1'b1;
                in_data[p*W +: W] = src_mem[p][src_rd[p]];
            end else begin
                in_valid[p]       = 1'b0;
                in_data[p*W +: W] = '0;
            end
        end
    endtask

    // Run n clock cycles of handshakes. Returns 1 time unit after a rising edge.
    task automatic applyStimulus(input int n);
        logic [NP-1:0] taken;
        for (int c = 0; c < n; c++) begin
            set_inputs();
            @(negedge clk);
            taken = in_valid & in_ready;
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (taken[p]) begin
                    src_rd[p]++;
                    acc_cnt[p]++;
                end
            end
            set_inputs();
        end
    endtask

    // Run until every expected packet has been seen, with a cycle bound
    task automatic drain(input string name);
        int c;
        c = 0;
        while ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0 && c < 400) begin
            applyStimulus(1);
            c++;
        end
        checkOutput({name, " pending"}, 64'(exp_q0.size() + exp_q1.size() + exp_q2.size()), 64'd0);
        applyStimulus(2);
    endtask

    // Scoreboard compare for one packet leaving output o
    task automatic scoreboard_pop(input int o, input logic [W-1:0] d);
        logic [W-1:0] e;
        bit           have;
        have = 1'b0;
        e    = '0;
        case (o)
            0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
            1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
            default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL out%0d unexpected: actual %0h, required no packet", o, d);
        end else begin
            checkOutput($sformatf("out%0d data", o), 64'(d), 64'(e));
        end
    endtask

    // Monitor: a handshake visible between edges completes at the next rising edge
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int o = 0; o < NP; o++) begin
                    if (out_valid[o] && out_ready[o]) begin
                        scoreboard_pop(o, out_data[o*W +: W]);
                    end
                end
            end
        end
    end

    // Directed sequence
    initial begin
        int first_beat;
        int last_beat;
        int beats;
        int base;
        int acc_at_stall;
        logic [W-1:0] held_pkt;

        for (int p = 0; p < NP; p++) begin
            src_wr[p]  = 0;
            src_rd[p]  = 0;
            acc_cnt[p] = 0;
        end
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset out_data", 64'(out_data), 64'd0);
        checkOutput("reset in_ready", 64'(in_ready), 64'b111);
        checkOutput("reset drop_cnt", 64'(drop_cnt), 64'd0);
        reset = 1'b0;

        // The parent sends dest=001. It reaches child 2 one cycle after acceptance.
        $display("[TB] parent to child2 latency");
        send(0, 3'b001, 11'b00000000101, 2);
        applyStimulus(1);
        checkOutput("t034 accepted first edge", 64'(acc_cnt[0]), 64'd1);
        applyStimulus(1);
        checkOutput("t034 out_valid", 64'(out_valid), 64'b100);
        checkOutput("t034 out_data2", 64'(out_data[2*W +: W]), 64'(14'b00100000000101));
        drain("t034");

        // Upward, downward and U-turn routing
        $display("[TB] child routing and U-turn");
        send(1, 3'b010, 11'h011, 0);
        drain("t035 child1 up");
        send(2, 3'b000, 11'h022, 1);
        drain("t035 child2 to child1");
        send(1, 3'b000, 11'h033, 1);
        drain("t035 u-turn");

        // Fresh pointers, then all three inputs compete for output 1
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        $display("[TB] round robin on port 1");
        for (int s = 0; s < 4; s++) begin
            for (int p = 0; p < NP; p++) begin
                send(p, 3'b000, 11'(p * 16 + s), 1);
            end
        end
        first_beat = -1;
        last_beat  = -1;
        beats      = 0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus(1);
            if (out_valid[1]) begin
                if (first_beat < 0) first_beat = c;
                last_beat = c;
                beats++;
            end
        end
        checkOutput("t036 beats", 64'(beats), 64'd12);
        checkOutput("t036 back-to-back", 64'(last_beat - first_beat + 1), 64'd12);
        drain("t036");

        // Backpressure on output 1 while child 2 streams into it
        $display("[TB] backpressure on port 1");
        out_ready[1] = 1'b0;
        base         = acc_cnt[2];
        acc_at_stall = -1;
        held_pkt     = {3'b000, 11'h100};
        for (int i = 0; i < 6; i++) begin
            send(2, 3'b000, 11'(256 + i), 1);
        end
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1);
            if (!in_ready[2] && acc_at_stall < 0) acc_at_stall = acc_cnt[2] - base;
            if (c >= 1) begin
                checkOutput($sformatf("t037 held valid c%0d", c), 64'(out_valid[1]), 64'd1);
                checkOutput($sformatf("t037 held data c%0d", c), 64'(out_data[W +: W]), 64'(held_pkt));
            end
        end
        checkOutput("t037 accepted before stall", 64'(acc_at_stall), 64'd3);
        checkOutput("t037 accepted during stall", 64'(acc_cnt[2] - base), 64'd3);
        out_ready[1] = 1'b1;
        drain("t037");

        // Unroutable packets from the parent are dropped and counted
        $display("[TB] drops and saturation");
        send(0, 3'b100, 11'h055, -1);
        applyStimulus(4);
        checkOutput("t038 drop_cnt one", 64'(drop_cnt), 64'd1);
        for (int i = 0; i < 299; i++) begin
            send(0, 3'b100, 11'(i), -1);
        end
        applyStimulus(310);
        checkOutput("t038 drop_cnt saturated", 64'(drop_cnt), 64'd255);

        // Asynchronous reset with packets in flight
        $display("[TB] reset with buffered packets");
        out_ready[1] = 1'b0;
        send(1, 3'b000, 11'h066, -1);
        send(1, 3'b000, 11'h067, -1);
        applyStimulus(3);
        checkOutput("t039 pre-reset out_valid1", 64'(out_valid[1]), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t039 async out_valid", 64'(out_valid), 64'd0);
        checkOutput("t039 async drop_cnt", 64'(drop_cnt), 64'd0);
        checkOutput("t039 async in_ready", 64'(in_ready), 64'b111);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = '1;
        base      = acc_cnt[2];
        send(2, 3'b001, 11'h077, 2);
        applyStimulus(1);
        checkOutput("t039 accept after reset", 64'(acc_cnt[2] - base), 64'd1);
        drain("t039");
        applyStimulus(5);

        checkOutput("final pending", 64'(exp_q0.size() + exp_q1.size() + exp_q2.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/tree_router_rr.md
TREE_ROUTER_RR -- requirements
Module: tree_router_rr

Interface
REQ-001 Parameter WIDTH_packet, default 14: packet width in bits.
REQ-002 Parameter WIDTH_addr, default 3: destination and node address width.
REQ-003 Parameter NUM_CHILD, default 2: number of child ports; legal range 2..8; NP = NUM_CHILD+1.
REQ-004 Parameter DEPTH, default 2: per-input FIFO depth; power of two, at least 2.
REQ-005 Parameter MASK, default 3'b110: address bits that define this router's subtree.
REQ-006 Parameter ADDR, default 3'b000: subtree base address.
REQ-007 Parameter CSEL_LSB, default 0: LSB of the child-select field in dest; CW = clog2(NUM_CHILD) bits.
REQ-008 Parameter IS_ROOT, default 0: 1 means no parent port is used.
REQ-009 clk  input  1  single clock; all state changes on the rising edge.
REQ-010 reset  input  1  asynchronous, active-high reset.
REQ-011 in_data  input  NP*WIDTH_packet  packed input packets; slice p is port p (0 = parent, 1..NUM_CHILD = children).
REQ-012 in_valid  input  NP  per-port packet-present flag.
REQ-013 in_ready  output  NP  per-port accept flag.
REQ-014 out_data  output  NP*WIDTH_packet  packed output packets, same port order as in_data.
REQ-015 out_valid  output  NP  per-port output-present flag.
REQ-016 out_ready  input  NP  per-port downstream accept flag.
REQ-017 drop_cnt  output  8  saturating count of dropped packets.

Function
REQ-018 A transfer SHALL occur on any port at a rising edge where valid=1 and ready=1.
REQ-019 dest SHALL be in_data slice bits [WIDTH_packet-1 -: WIDTH_addr].
REQ-020 A packet SHALL be local when (dest & MASK) == (ADDR & MASK).
- Target port of a local packet: dest[CSEL_LSB +: CW] + 1.
- Target port of a non-local packet: 0.
REQ-021 Packets with an illegal target SHALL be dropped at the FIFO head and increment drop_cnt (saturate at 255).
- Illegal target: child index >= NUM_CHILD, a non-local packet received on port 0, or a non-local packet when IS_ROOT=1.
- Dropping consumes one FIFO pop in that cycle.
REQ-022 Each input SHALL have a DEPTH-entry FIFO.
- in_ready[p] = !full[p]; it is a registered-state function only, with no combinational path from out_ready.
- When full, a simultaneous pop does not raise in_ready in the same cycle.
REQ-023 When IS_ROOT=1, in_ready[0] SHALL be 1 and port-0 input SHALL be discarded without counting; out_valid[0] SHALL be 0.
REQ-024 Each output SHALL have one register stage, loadable when !out_valid[o] || out_ready[o].
- out_data[o] SHALL stay stable while out_valid[o]=1 and out_ready[o]=0.
REQ-025 Each output SHALL have a round-robin arbiter among FIFO heads targeting it.
- Search starts at (last granted port + 1) mod NP.
- The pointer updates only on a grant; it resets to NP-1, so port 0 has first priority.
REQ-026 Per output, at most one grant per cycle; per input, at most one pop per cycle; every grant SHALL pop exactly one entry.
REQ-027 Minimum latency: a packet accepted at edge k SHALL appear with out_valid=1 after edge k+1, given an empty FIFO, a free output and no competitor.
REQ-028 Full throughput: one packet per cycle per output under continuous out_ready=1.
REQ-029 U-turns (output port equal to the input port) SHALL be permitted.
REQ-030 Packet order per input-output pair SHALL be preserved; no packet SHALL be duplicated or lost except as defined in REQ-021 and REQ-023.

Reset
REQ-031 While reset=1, the block SHALL hold:
- all FIFOs empty;
- out_valid = 0, out_data = 0;
- drop_cnt = 0;
- arbiter pointers = NP-1;
- in_ready = 1 on all ports.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered and registered packets immediately, without waiting for a clock edge.
REQ-033 After deassertion, the first transfer SHALL be accepted at the next rising edge.

Verification
REQ-034 Parent sends 14'b001_00000000101 (dest=001) -> out_valid[2]=1 one cycle after acceptance, out_data[2]=14'b00100000000101.
REQ-035 Child1 sends dest=010 -> forwarded on port 0; child2 sends dest=000 -> forwarded on port 1 (U-turn case from child1 also checked).
REQ-036 Ports 0, 1, 2 all send dest=000 every cycle with out_ready[1]=1 -> grants on port 1 follow the order 0,1,2,0,1,2; one packet per cycle.
REQ-037 out_ready[1]=0 for 10 cycles with child2 streaming to port 1:
- in_ready[2] drops after DEPTH+1 accepted packets;
- out_data[1] stays stable;
- after release, all packets arrive in order.
REQ-038 Parent sends dest=100 -> nothing output, drop_cnt=1; 300 such packets -> drop_cnt=255.
REQ-039 Reset pulsed with 2 packets buffered -> out_valid=0 and drop_cnt=0 immediately; the buffered packets never appear.
